// File: rtl/keypad_encoder.sv
`timescale 1ns/1ps
// keypad_encoder
//   Scans a 4x4 calculator keypad, synchronizes and debounces the columns and
//   turns each press into one gencon event (digit strobe, operator code or
//   equal strobe), held back until gencon reports key_ready.
//
// Ports
//   clk            in   system clock
//   nRST           in   asynchronous active-low reset
//   col_n[3:0]     in   matrix columns, active-low, asynchronous to clk
//   row_n[3:0]     out  one-hot active-low row drive
//   key_ready      in   gencon can accept an event
//   keypad_input   out  last emitted digit 0-9
//   read_input     out  one-cycle digit strobe
//   operator_input out  one-cycle code: 001 neg, 010 add, 011 sub, 100 mul
//   equal_input    out  one-cycle equal strobe
//
// Build option
//   KEYPAD_AUTOREPEAT_EN : held digit keys re-emit every REPEAT_DLY cycles.
//
// state          | meaning
// S_SCAN         | rows cycle every SCAN_DIV cycles, look for exactly one low column
// S_DEBOUNCE     | row frozen, count cycles the latched column pattern stays put
// S_EMIT         | debounced key pending, waiting for key_ready
// S_WAIT_RELEASE | row frozen, count consecutive all-released cycles
module keypad_encoder #(
  parameter int unsigned SCAN_DIV     = 5000,
  parameter int unsigned DEBOUNCE_CNT = 250000,
  parameter int unsigned REPEAT_DLY   = 25000000
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  input  logic       key_ready,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

  if (!(SCAN_DIV >= 4 && DEBOUNCE_CNT >= 1 && REPEAT_DLY >= 1)) begin : g_bad_cfg
    $error("keypad_encoder: illegal parameter set");
  end

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_WAIT_RELEASE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          col_meta, col_s;
  logic [1:0]          row_idx;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic [3:0]          key_pat;
  logic [1:0]          key_row, key_col;

  logic                one_low;
  logic [1:0]          low_col;
  logic                scan_last, deb_hit, key_match, all_up, cnt_cond;
  logic                latch, row_adv, emit_fire;
  logic [3:0]          dec_digit;
  logic                dec_is_digit, dec_eq;
  logic [2:0]          dec_op;

  assign row_n     = ~(4'b0001 << row_idx);
  assign scan_last = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign deb_hit   = (deb_cnt == DEB_W'(DEBOUNCE_CNT - 1));
  assign key_match = (col_s == key_pat);
  assign all_up    = (col_s == 4'hF);

  always_comb begin
    one_low = 1'b0;
    low_col = 2'd0;
    case (col_s)
      4'b1110: begin one_low = 1'b1; low_col = 2'd0; end
      4'b1101: begin one_low = 1'b1; low_col = 2'd1; end
      4'b1011: begin one_low = 1'b1; low_col = 2'd2; end
      4'b0111: begin one_low = 1'b1; low_col = 2'd3; end
      default: ;
    endcase
  end

  // Row 3 is special (negate, 0, unused, equal); column 3 carries the
  // operators add/sub/mul whose codes are row+2.
  always_comb begin
    dec_digit    = 4'd0;
    dec_is_digit = 1'b0;
    dec_op       = 3'd0;
    dec_eq       = 1'b0;
    if (key_row == 2'd3) begin
      case (key_col)
        2'd0:    dec_op = 3'b001;
        2'd1:    dec_is_digit = 1'b1;
        2'd3:    dec_eq = 1'b1;
        default: ;
      endcase
    end else if (key_col == 2'd3) begin
      dec_op = {1'b0, key_row} + 3'd2;
    end else begin
      dec_is_digit = 1'b1;
      dec_digit    = ({2'b00, key_row} * 4'd3) + {2'b00, key_col} + 4'd1;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DLY + 1);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_hit;
  assign rpt_hit = (rpt_cnt == RPT_W'(REPEAT_DLY - 1));

  // Hold time only accumulates while the same key stays down in WAIT_RELEASE.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)
      rpt_cnt <= '0;
    else if (state == S_WAIT_RELEASE && key_match && !rpt_hit)
      rpt_cnt <= rpt_cnt + 1'b1;
    else
      rpt_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= S_SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    row_adv   = 1'b0;
    emit_fire = 1'b0;
    case (state)
      S_SCAN: begin
        if (scan_last) begin
          if (one_low) begin
            latch     = 1'b1;
            state_nxt = S_DEBOUNCE;
          end else begin
            row_adv = 1'b1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (!key_match) begin
          row_adv   = 1'b1;
          state_nxt = S_SCAN;
        end else if (deb_hit) begin
          state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (key_ready) begin
          emit_fire = 1'b1;
          state_nxt = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (all_up && deb_hit) begin
          row_adv   = 1'b1;
          state_nxt = S_SCAN;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rpt_hit && dec_is_digit) begin
          state_nxt = S_EMIT;
        end
`endif
      end
      default: state_nxt = S_SCAN;
    endcase
  end

  always_comb begin
    case (state)
      S_DEBOUNCE:     cnt_cond = key_match;
      S_WAIT_RELEASE: cnt_cond = all_up;
      default:        cnt_cond = 1'b0;
    endcase
  end

  // scan_cnt sits at 0 outside SCAN so every return to SCAN starts a full row period.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
      row_idx  <= 2'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      key_pat  <= 4'hF;
      key_row  <= 2'd0;
      key_col  <= 2'd0;
    end else begin
      col_meta <= col_n;
      col_s    <= col_meta;
      if (row_adv)
        row_idx <= row_idx + 2'd1;
      scan_cnt <= (state == S_SCAN && !scan_last) ? scan_cnt + 1'b1 : '0;
      if (!cnt_cond)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_W'(DEBOUNCE_CNT))
        deb_cnt <= deb_cnt + 1'b1;
      if (latch) begin
        key_pat <= col_s;
        key_row <= row_idx;
        key_col <= low_col;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      keypad_input   <= 4'd0;
      read_input     <= 1'b0;
      operator_input <= 3'd0;
      equal_input    <= 1'b0;
    end else begin
      read_input     <= 1'b0;
      operator_input <= 3'd0;
      equal_input    <= 1'b0;
      if (emit_fire) begin
        if (dec_is_digit) begin
          keypad_input <= dec_digit;
          read_input   <= 1'b1;
        end
        operator_input <= dec_op;
        equal_input    <= dec_eq;
      end
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
`timescale 1ns/1ps
module tb_keypad_encoder;
  localparam int SCAN_DIV     = 8;
  localparam int DEBOUNCE_CNT = 4;
  localparam int REPEAT_DLY   = 40;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        key_ready = 1'b1;
  logic [15:0] pressed = '0;
  logic        bounce = 1'b0;
  logic [3:0]  col_n, row_n, keypad_input;
  logic        read_input, equal_input;
  logic [2:0]  operator_input;

  int total = 0, bad = 0;
  int n_read = 0, n_op = 0, n_eq = 0, n_ovl = 0;
  int last_digit = -1, last_op = -1;
  int b = 0, op0 = 0, eq0 = 0, exp_zero = 0;

  keypad_encoder #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .REPEAT_DLY(REPEAT_DLY)
  ) dut (
    .clk(clk), .nRST(nRST), .col_n(col_n), .row_n(row_n), .key_ready(key_ready),
    .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls column c low while row r is driven low; bounce opens all contacts.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    if (bounce) col_n = 4'hF;
  end

  always @(negedge clk) begin
    if (read_input) begin n_read++; last_digit = int'(keypad_input); end
    if (operator_input != 3'd0) begin n_op++; last_op = int'(operator_input); end
    if (equal_input) n_eq++;
    if (int'(read_input) + int'(operator_input != 3'd0) + int'(equal_input) > 1) n_ovl++;
  end

  function automatic int ev_total();
    return n_read + n_op + n_eq;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_ev(input string tag, input int target, input int budget);
    int k = 0;
    while (ev_total() < target && k < budget) begin
      cycles(1);
      k++;
    end
    chk(tag, ev_total(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cycles(3);
    chk("rst_row_n", int'(row_n), 4'b1110);
    chk("rst_read", int'(read_input), 0);
    chk("rst_op", int'(operator_input), 0);
    chk("rst_eq", int'(equal_input), 0);
    chk("rst_kp", int'(keypad_input), 0);
    nRST = 1'b1;
    cycles(2);

    // "5" held well past the event
    b = ev_total();
    pressed[5] = 1'b1;
    wait_ev("t1_event", b + 1, 200);
    chk("t1_digit", last_digit, 5);
    cycles(20);
    chk("t1_no_repeat_while_held", ev_total(), b + 1);
    pressed = '0;
    cycles(40);
    chk("t1_quiet_after_release", ev_total(), b + 1);
    chk("t1_kp_holds", int'(keypad_input), 5);

    // subtract, then equal
    b = ev_total(); op0 = n_op; eq0 = n_eq;
    pressed[7] = 1'b1;
    wait_ev("t2_sub_event", b + 1, 200);
    chk("t2_sub_code", last_op, 3);
    chk("t2_sub_count", n_op - op0, 1);
    pressed = '0;
    cycles(40);
    pressed[15] = 1'b1;
    wait_ev("t2_eq_event", b + 2, 200);
    chk("t2_eq_count", n_eq - eq0, 1);
    pressed = '0;
    cycles(40);
    chk("t2_no_overlap", n_ovl, 0);

    // "7" with two 2-cycle bounce glitches
    b = ev_total();
    pressed[8] = 1'b1;
    cycles(2); bounce = 1'b1;
    cycles(2); bounce = 1'b0;
    cycles(2); bounce = 1'b1;
    cycles(2); bounce = 1'b0;
    wait_ev("t3_event", b + 1, 200);
    cycles(10);
    chk("t3_single_event", ev_total(), b + 1);
    chk("t3_digit", last_digit, 7);
    pressed = '0;
    cycles(40);

    // "1" pending behind key_ready=0
    key_ready = 1'b0;
    b = ev_total();
    pressed[0] = 1'b1;
    cycles(60);
    chk("t4_held_off", ev_total(), b);
    key_ready = 1'b1;
    cycles(1);
    chk("t4_read_after_ready", int'(read_input), 1);
    chk("t4_digit", int'(keypad_input), 1);
    cycles(1);
    chk("t4_pulse_width", int'(read_input), 0);
    pressed = '0;
    cycles(40);

    // "3" released while pending still emits
    key_ready = 1'b0;
    b = ev_total();
    pressed[2] = 1'b1;
    cycles(60);
    pressed = '0;
    cycles(10);
    chk("t4b_held_off", ev_total(), b);
    key_ready = 1'b1;
    wait_ev("t4b_event", b + 1, 10);
    chk("t4b_digit", last_digit, 3);
    cycles(40);

    // two columns in the same row
    b = ev_total();
    pressed[4] = 1'b1; pressed[5] = 1'b1;
    cycles(100);
    chk("t5_two_cols_no_event", ev_total(), b);
    pressed = '0;
    cycles(10);

    // reset while debouncing "6" (r1c2)
    nRST = 1'b0;
    cycles(2);
    pressed[6] = 1'b1;
    cycles(2);
    nRST = 1'b1;
    cycles(18);
    chk("t5_row1_frozen", int'(row_n), 4'b1101);
    nRST = 1'b0;
    #1;
    chk("t5_rst_row_n", int'(row_n), 4'b1110);
    chk("t5_rst_kp", int'(keypad_input), 0);
    chk("t5_rst_read", int'(read_input), 0);
    chk("t5_rst_op", int'(operator_input), 0);
    chk("t5_rst_eq", int'(equal_input), 0);
    pressed = '0;
    cycles(3);
    nRST = 1'b1;
    cycles(80);
    chk("t5_no_event_after_rst", ev_total(), b);

    // "0" held; repeats only with auto-repeat
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_zero = 3;
`else
    exp_zero = 1;
`endif
    b = ev_total();
    pressed[13] = 1'b1;
    wait_ev("t6_zero_first", b + 1, 200);
    cycles(90);
    pressed = '0;
    cycles(40);
    chk("t6_zero_events", ev_total() - b, exp_zero);
    chk("t6_zero_digit", last_digit, 0);

    // multiply held never repeats
    b = ev_total();
    pressed[11] = 1'b1;
    wait_ev("t6_mul_first", b + 1, 200);
    cycles(90);
    pressed = '0;
    cycles(40);
    chk("t6_mul_events", ev_total() - b, 1);
    chk("t6_mul_code", last_op, 4);
    chk("t6_no_overlap", n_ovl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
